// File: rtl/ex_mdu_if.sv
// Request/response bundle between the pipeline control and the iterative
// multiply/divide unit.
interface ex_mdu_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic [XLEN-1:0] rd_data_o;
    logic [4:0]      rd_addr_o;
    logic            rd_wen_o;
    logic            hold_flag_o;
    logic            busy_o;

    modport master (
        output start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
        input  rd_data_o, rd_addr_o, rd_wen_o, hold_flag_o, busy_o
    );

    modport slave (
        input  start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
        output rd_data_o, rd_addr_o, rd_wen_o, hold_flag_o, busy_o
    );
endinterface

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand
// magnitudes, sign correction applied when the result is registered.
module ex_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic    clk,
    input logic    rst,
    ex_mdu_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REMU   = 3'b111;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [4:0]        raddr_q, raddr_d;
    logic              wen_q, wen_d;

    logic              accept;
    logic              op1_signed, op2_signed, n1, n2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, div_ovf;
    logic [XLEN:0]     msum;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt, prod;
    logic [2*XLEN:0]   dsh;
    logic [XLEN:0]     ddiff;
    logic [XLEN-1:0]   quo, rem, res;

    assign accept     = (state_q == S_IDLE) && bus.start_i && !bus.flush_i;
    assign op1_signed = !(bus.op_i inside {OP_MULHU, OP_DIVU, OP_REMU});
    assign op2_signed = op1_signed && (bus.op_i != OP_MULHSU);
    assign n1         = op1_signed && bus.op1_i[XLEN-1];
    assign n2         = op2_signed && bus.op2_i[XLEN-1];
    assign mag1       = n1 ? -bus.op1_i : bus.op1_i;
    assign mag2       = n2 ? -bus.op2_i : bus.op2_i;
    assign div_zero   = bus.op_i[2] && (bus.op2_i == '0);
    assign div_ovf    = bus.op_i[2] && !bus.op_i[0] &&
                        (bus.op1_i == MIN_NEG) && (bus.op2_i == '1);

    // Shift-add: multiplier sits in the low half of acc and drains out to the right.
    assign msum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_nxt = {msum, acc_q[XLEN-1:1]};

    // Restoring divide: partial remainder in the high half, quotient bits shift in low.
    assign dsh     = {acc_q, 1'b0};
    assign ddiff   = dsh[2*XLEN:XLEN] - {1'b0, b_q};
    assign div_nxt = ddiff[XLEN] ? dsh[2*XLEN-1:0]
                                 : {ddiff[XLEN-1:0], dsh[XLEN-1:1], 1'b1};
    assign acc_nxt = op_q[2] ? div_nxt : mul_nxt;

    assign prod = neg_q  ? -acc_nxt : acc_nxt;
    assign quo  = neg_q  ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    assign rem  = rneg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];

    always_comb begin
        res = quo;
        if (!op_q[2])     res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (op_q[1]) res = rem;
    end

    always_comb begin
        // NOTE: every _d starts from its _q (or zero) so no path can infer a latch.
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        data_d  = '0;
        raddr_d = '0;
        wen_d   = 1'b0;

        case (state_q)
            S_IDLE: if (accept) begin
                op_d   = bus.op_i;
                addr_d = bus.rd_addr_i;
                cnt_d  = '0;
                b_d    = bus.op_i[2] ? mag2 : mag1;
                acc_d  = {{XLEN{1'b0}}, bus.op_i[2] ? mag1 : mag2};
                neg_d  = n1 ^ n2;
                rneg_d = n1;
                if (div_zero || div_ovf) begin
                    state_d = S_DONE;
                    wen_d   = 1'b1;
                    raddr_d = bus.rd_addr_i;
                    if (div_zero) data_d = bus.op_i[1] ? bus.op1_i : '1;
                    else          data_d = bus.op_i[1] ? '0 : bus.op1_i;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = acc_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = S_DONE;
                    wen_d   = 1'b1;
                    data_d  = res;
                    raddr_d = addr_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            data_d  = '0;
            raddr_d = '0;
            wen_d   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            data_q  <= '0;
            raddr_q <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            data_q  <= data_d;
            raddr_q <= raddr_d;
            wen_q   <= wen_d;
        end
    end

    // A flush landing on the write cycle must kill the strobe in that same cycle.
    assign bus.rd_wen_o    = wen_q && !bus.flush_i;
    assign bus.rd_data_o   = data_q;
    assign bus.rd_addr_o   = raddr_q;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.hold_flag_o = accept || (state_q == S_CALC);
endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: 32-bit and 16-bit instances, directed corner
// cases plus random traffic against a wide-integer reference model.
module tb_ex_mdu;
    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        int          cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];

    ex_mdu_if #(.XLEN(32)) if32 ();
    ex_mdu_if #(.XLEN(16)) if16 ();

    ex_mdu #(.XLEN(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    ex_mdu #(.XLEN(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RISC-V M semantics computed on 128-bit integers.
    function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b, int w);
        logic signed [127:0] x, y, p, q, r;
        logic [127:0] mask;
        bit s1, s2;
        mask = (128'(1) << w) - 128'(1);
        s1 = (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
        s2 = (op inside {3'd0, 3'd1, 3'd4, 3'd6});
        x = 128'(a) & mask;
        y = 128'(b) & mask;
        if (s1 && a[w-1]) x = x | ~mask;
        if (s2 && b[w-1]) y = y | ~mask;
        if (!op[2]) begin
            p = x * y;
            if (op == 3'd0) return 32'(p & mask);
            return 32'((p >>> w) & mask);
        end
        if (y == 0) return op[1] ? 32'(x & mask) : 32'(mask);
        q = x / y;
        r = x % y;
        return op[1] ? 32'(r & mask) : 32'(q & mask);
    endfunction

    function automatic logic get_busy(int w);
        return (w == 32) ? if32.busy_o : if16.busy_o;
    endfunction
    function automatic logic get_hold(int w);
        return (w == 32) ? if32.hold_flag_o : if16.hold_flag_o;
    endfunction
    function automatic logic get_wen(int w);
        return (w == 32) ? if32.rd_wen_o : if16.rd_wen_o;
    endfunction

    task automatic drive(int w, logic s, logic f, logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] ad);
        if (w == 32) begin
            if32.start_i = s; if32.flush_i = f; if32.op_i = op;
            if32.op1_i = a;   if32.op2_i = b;   if32.rd_addr_i = ad;
        end else begin
            if16.start_i = s; if16.flush_i = f; if16.op_i = op;
            if16.op1_i = a[15:0]; if16.op2_i = b[15:0]; if16.rd_addr_i = ad;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle; call while the unit is idle.
    task automatic issue(int w, logic [2:0] op, logic [31:0] a_in, logic [31:0] b_in, logic [4:0] ad, bit expect_wr);
        logic [31:0] m, a, b;
        bit fast;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        a = a_in & m;
        b = b_in & m;
        fast = op[2] && ((b == 0) || (!op[0] && (a == (32'(1) << (w - 1))) && (b == m)));
        drive(w, 1'b1, 1'b0, op, a, b, ad);
        #1;
        check($sformatf("hold_accept_w%0d", w), 64'(get_hold(w)), 64'd1);
        if (expect_wr) begin
            if (w == 32) q32.push_back('{ref_model(op, a, b, w), ad, cyc + 1 + (fast ? 0 : w)});
            else         q16.push_back('{ref_model(op, a, b, w), ad, cyc + 1 + (fast ? 0 : w)});
        end
        step();
        drive(w, 1'b0, 1'b0, 3'($urandom), $urandom, $urandom, 5'($urandom));
        check($sformatf("hold_after_accept_w%0d", w), 64'(get_hold(w)), fast ? 64'd0 : 64'd1);
    endtask

    task automatic wait_idle(int w);
        for (int i = 0; i < 3 * w + 10; i++) begin
            if (!get_busy(w)) break;
            step();
        end
        check($sformatf("idle_timeout_w%0d", w), 64'(get_busy(w)), 64'd0);
    endtask

    function automatic logic [31:0] pick(int w);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'(1) << (w - 1);
            3:       return 32'($urandom_range(1, 9));
            4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (if32.rd_wen_o) begin
            if (q32.size() == 0) check("w32_spurious_wen", 64'(if32.rd_wen_o), 64'd0);
            else begin
                e = q32.pop_front();
                check("w32_data", 64'(if32.rd_data_o), 64'(e.data));
                check("w32_addr", 64'(if32.rd_addr_o), 64'(e.addr));
                check("w32_latency", 64'(cyc), 64'(e.cyc));
            end
        end else if (!if32.flush_i) begin
            check("w32_idle_zero", {27'd0, if32.rd_addr_o, if32.rd_data_o}, 64'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if16.rd_wen_o) begin
            if (q16.size() == 0) check("w16_spurious_wen", 64'(if16.rd_wen_o), 64'd0);
            else begin
                e = q16.pop_front();
                check("w16_data", 64'(if16.rd_data_o), 64'(e.data));
                check("w16_addr", 64'(if16.rd_addr_o), 64'(e.addr));
                check("w16_latency", 64'(cyc), 64'(e.cyc));
            end
        end else if (!if16.flush_i) begin
            check("w16_idle_zero", {43'd0, if16.rd_addr_o, if16.rd_data_o}, 64'd0);
        end
    end

    initial begin
        logic [31:0] mn;
        int w;
        rst = 1'b0;
        drive(32, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        drive(16, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_wen",  64'(if32.rd_wen_o), 64'd0);
        check("rst_data", 64'(if32.rd_data_o), 64'd0);
        check("rst_addr", 64'(if32.rd_addr_o), 64'd0);
        check("rst_hold", 64'(if32.hold_flag_o), 64'd0);
        check("rst_busy", 64'(if32.busy_o), 64'd0);

        // Start is presented together with reset release: first rising edge accepts it.
        @(negedge clk);
        rst = 1'b1;
        issue(32, 3'd0, 32'hFFFF_FFFF, 32'd7, 5'd1, 1'b1);
        wait_idle(32);

        for (int k = 0; k < 2; k++) begin
            w  = (k == 0) ? 32 : 16;
            mn = 32'(1) << (w - 1);
            if (w == 16) begin
                issue(w, 3'd0, 32'hFFFF_FFFF, 32'd7, 5'd1, 1'b1); wait_idle(w);
            end
            issue(w, 3'd1, 32'hFFFF_FFFF, 32'd7, 5'd2, 1'b1);          wait_idle(w);
            issue(w, 3'd3, 32'hFFFF_FFFF, 32'd7, 5'd3, 1'b1);          wait_idle(w);
            issue(w, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1);          wait_idle(w);
            issue(w, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1);          wait_idle(w);
            issue(w, 3'd5, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);          wait_idle(w);
            issue(w, 3'd5, 32'h1234_5678, 32'd0, 5'd7, 1'b1);          wait_idle(w);
            issue(w, 3'd7, 32'h1234_5678, 32'd0, 5'd8, 1'b1);          wait_idle(w);
            issue(w, 3'd4, mn, 32'hFFFF_FFFF, 5'd9, 1'b1);             wait_idle(w);
            issue(w, 3'd6, mn, 32'hFFFF_FFFF, 5'd10, 1'b1);            wait_idle(w);
            issue(w, 3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd11, 1'b1); wait_idle(w);
        end

        // A second start while busy must be ignored.
        issue(32, 3'd4, 32'd1000, 32'd7, 5'd5, 1'b1);
        repeat (3) step();
        drive(32, 1'b1, 1'b0, 3'd0, 32'd3, 32'd4, 5'd9);
        #1;
        check("hold_busy_calc", 64'(if32.hold_flag_o), 64'd1);
        step();
        drive(32, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        wait_idle(32);

        // Flush during the tenth CALC cycle aborts silently; a later start completes.
        issue(32, 3'd0, $urandom, $urandom, 5'd12, 1'b0);
        repeat (9) step();
        drive(32, 1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 5'd0);
        step();
        drive(32, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        check("flush_calc_busy", 64'(if32.busy_o), 64'd0);
        check("flush_calc_hold", 64'(if32.hold_flag_o), 64'd0);
        check("flush_calc_wen",  64'(if32.rd_wen_o), 64'd0);
        repeat (2) step();
        issue(32, 3'd1, 32'h8000_0001, 32'h7FFF_FFFF, 5'd13, 1'b1);
        wait_idle(32);

        // Flush in the write cycle kills the strobe combinationally.
        issue(32, 3'd5, 32'hABCD, 32'd0, 5'd14, 1'b0);
        drive(32, 1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 5'd0);
        #1;
        check("flush_done_wen", 64'(if32.rd_wen_o), 64'd0);
        step();
        drive(32, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        check("flush_done_busy", 64'(if32.busy_o), 64'd0);

        // Start together with flush in IDLE is not accepted.
        drive(32, 1'b1, 1'b1, 3'd0, 32'd5, 32'd6, 5'd15);
        #1;
        check("start_flush_hold", 64'(if32.hold_flag_o), 64'd0);
        step();
        drive(32, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        check("start_flush_busy", 64'(if32.busy_o), 64'd0);

        // Asynchronous reset in the fifth CALC cycle.
        issue(32, 3'd4, 32'd100, 32'd3, 5'd16, 1'b0);
        repeat (4) step();
        #2;
        rst = 1'b0;
        #1;
        check("rst_calc_wen",  64'(if32.rd_wen_o), 64'd0);
        check("rst_calc_data", 64'(if32.rd_data_o), 64'd0);
        check("rst_calc_addr", 64'(if32.rd_addr_o), 64'd0);
        check("rst_calc_hold", 64'(if32.hold_flag_o), 64'd0);
        check("rst_calc_busy", 64'(if32.busy_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        for (int i = 0; i < 150; i++) begin
            issue(32, 3'($urandom), pick(32), pick(32), 5'($urandom), 1'b1);
            wait_idle(32);
        end
        for (int i = 0; i < 60; i++) begin
            issue(16, 3'($urandom), pick(16), pick(16), 5'($urandom), 1'b1);
            wait_idle(16);
        end

        repeat (3) step();
        check("sb32_drained", 64'(q32.size()), 64'd0);
        check("sb16_drained", 64'(q16.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
